mips_bus_arbiter: RTL and testbench
===================================

MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 Parameter: WAIT_LIMIT, 255, max consecutive slave-stall cycles before forced release (used only with the Configuration feature).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserts immediately, deasserts synchronously to clk.
REQ-004 m0_address/m0_writedata  input  32 each; m0_byteenable  input  4; m0_read, m0_write  input  1 each: master 0 (instruction fetch) request.
REQ-005 m0_readdata  output  32; m0_waitrequest  output  1: master 0 response.
REQ-006 m1_address/m1_writedata  input  32 each; m1_byteenable  input  4; m1_read, m1_write  input  1 each: master 1 (data port) request.
REQ-007 m1_readdata  output  32; m1_waitrequest  output  1: master 1 response.
REQ-008 s_address/s_writedata  output  32 each; s_byteenable  output  4; s_read, s_write  output  1 each: shared memory slave request.
REQ-009 s_readdata  input  32; s_waitrequest  input  1: slave response.
REQ-010 owner  output  2: 00 idle, 01 master 0 granted, 10 master 1 granted.
REQ-011 timeout_err  output  1: sticky forced-release flag.

Function
REQ-012 FSM states IDLE, GRANT0, GRANT1; owner is registered and encodes the state directly.
REQ-013 Request of master x = mx_read OR mx_write.
REQ-014 IDLE: s_read=s_write=0, s_address=s_writedata=0, s_byteenable=0.
REQ-015 IDLE -> GRANTx on next edge when only master x requests; if both request, the master not in last_grant wins (round-robin).
REQ-016 GRANTx: s_address, s_writedata, s_byteenable, s_read, s_write are combinational copies of master x inputs; mx_waitrequest = s_waitrequest.
REQ-017 If master x asserts read and write together, s_write is forwarded and s_read is forced 0.
REQ-018 Non-owner master: waitrequest=1 whenever it requests, 0 otherwise; no slave signal is driven from it.
REQ-019 m0_readdata and m1_readdata both equal s_readdata in every cycle; only the owner's copy is meaningful.
REQ-020 Completion: cycle in GRANTx with request asserted and s_waitrequest=0; last_grant<=x at that edge.
REQ-021 At completion edge: if the other master requests -> GRANT(other); else -> IDLE (same master re-arbitrates, so one idle cycle between its back-to-back transfers).
REQ-022 Owner dropping its request before completion: abandon, -> IDLE next edge, last_grant unchanged.
REQ-023 Grant latency: request seen in IDLE -> slave sees it the following cycle; minimum 2 cycles per uncontended transfer with zero-wait slave.
REQ-024 No combinational path from s_waitrequest to any s_* output.

Reset
REQ-025 reset=0: state IDLE, owner=00, last_grant=1 (master 0 wins first tie), timeout_err=0, stall counter=0; s_read/s_write drop in the same cycle, including mid-transfer.
REQ-026 Requests held during reset are arbitrated starting the first edge after reset release.

Configuration
REQ-027 Macro ARB_TIMEOUT_EN defined: 8-bit-minimum counter counts consecutive GRANTx cycles with s_waitrequest=1; cleared on completion, grant change or IDLE.
REQ-028 With ARB_TIMEOUT_EN, when counter reaches WAIT_LIMIT: owner's waitrequest=0 for that cycle, owner's readdata=32'hFFFFFFFF, timeout_err<=1 (cleared only by reset), transition as on completion.
REQ-029 Without ARB_TIMEOUT_EN: no counter, timeout_err tied 0, arbiter waits on s_waitrequest indefinitely.

Verification
REQ-030 Master 0 read 0xBFC00000, slave zero-wait returns 0x24020005 -> owner 01 one cycle after request, m0_readdata=0x24020005 with m0_waitrequest=0, then owner 00.
REQ-031 Both masters request from reset -> master 0 granted first, master 1 granted at master 0 completion edge with no IDLE cycle, m1_waitrequest=1 throughout master 0 transfer.
REQ-032 Both masters request continuously for 8 transfers -> grants alternate 01,10,01,10...; neither starves.
REQ-033 Master 1 write 0x12345678, byteenable 4'b0011, slave stalls 3 cycles -> s_* stable for 4 cycles, m1_waitrequest mirrors s_waitrequest, completion on cycle 4.
REQ-034 reset pulled low mid-GRANT1 stall -> s_write=0 and owner=00 immediately; after release, pending master 1 re-granted.
REQ-035 ARB_TIMEOUT_EN, WAIT_LIMIT=4, slave holds waitrequest=1 -> 4th stall cycle releases master with readdata 0xFFFFFFFF, timeout_err=1 sticky; without macro master stays stalled, timeout_err=0.

Source files
------------

// File: rtl/mips_bus_arbiter.sv
// Two-master round-robin arbiter sharing one memory slave between MIPS fetch and data ports.
// Define ARB_TIMEOUT_EN to add the slave-stall watchdog with the sticky timeout_err flag.
module mips_bus_arbiter #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  input  logic        m0_read,
  input  logic        m0_write,
  output logic [31:0] m0_readdata,
  output logic        m0_waitrequest,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  input  logic        m1_read,
  input  logic        m1_write,
  output logic [31:0] m1_readdata,
  output logic        m1_waitrequest,
  output logic [31:0] s_address,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  output logic        s_read,
  output logic        s_write,
  input  logic [31:0] s_readdata,
  input  logic        s_waitrequest,
  output logic [1:0]  owner,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  state_t state, state_next;
  logic   last_grant, last_grant_next;
  logic   req0, req1;
  logic   active;
  logic   done;
  logic   timeout;

  assign req0   = m0_read | m0_write;
  assign req1   = m1_read | m1_write;
  assign active = ((state == GRANT0) && req0) || ((state == GRANT1) && req1);
  assign done   = active && (!s_waitrequest || timeout);
  assign owner  = state;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = ($clog2(WAIT_LIMIT + 1) > 8) ? $clog2(WAIT_LIMIT + 1) : 8;
  localparam logic [CW-1:0] LIMIT_M1 = CW'(WAIT_LIMIT - 1);

  logic [CW-1:0] stall_cnt;

  // The limit-th consecutive stall cycle itself is the release cycle.
  assign timeout = active && s_waitrequest && (stall_cnt == LIMIT_M1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      stall_cnt <= (active && s_waitrequest && !timeout) ? stall_cnt + 1'b1 : '0;
      if (timeout)
        timeout_err <= 1'b1;
    end
  end
`else
  assign timeout     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // Completion hands the bus straight to a waiting peer; the finishing master must re-arbitrate.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (req0 && req1)
          state_next = last_grant ? GRANT0 : GRANT1;
        else if (req0)
          state_next = GRANT0;
        else if (req1)
          state_next = GRANT1;
      end
      GRANT0: begin
        if (!req0) begin
          state_next = IDLE;
        end else if (done) begin
          last_grant_next = 1'b0;
          state_next      = req1 ? GRANT1 : IDLE;
        end
      end
      GRANT1: begin
        if (!req1) begin
          state_next = IDLE;
        end else if (done) begin
          last_grant_next = 1'b1;
          state_next      = req0 ? GRANT0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Slave side depends only on state and master inputs, never on s_waitrequest.
  always_comb begin
    s_address      = '0;
    s_writedata    = '0;
    s_byteenable   = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    m0_waitrequest = req0;
    m1_waitrequest = req1;
    m0_readdata    = s_readdata;
    m1_readdata    = s_readdata;
    case (state)
      GRANT0: begin
        s_address      = m0_address;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        s_write        = m0_write;
        s_read         = m0_read & ~m0_write;
        m0_waitrequest = s_waitrequest & ~timeout;
        if (timeout)
          m0_readdata = 32'hFFFF_FFFF;
      end
      GRANT1: begin
        s_address      = m1_address;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        s_write        = m1_write;
        s_read         = m1_read & ~m1_write;
        m1_waitrequest = s_waitrequest & ~timeout;
        if (timeout)
          m1_readdata = 32'hFFFF_FFFF;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed testbench for mips_bus_arbiter; the slave is driven directly from the stimulus.
// Builds for both the plain and the ARB_TIMEOUT_EN configuration (WAIT_LIMIT = 4).
module tb_mips_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] m0_address, m0_writedata, m0_readdata;
  logic [3:0]  m0_byteenable;
  logic        m0_read, m0_write, m0_waitrequest;
  logic [31:0] m1_address, m1_writedata, m1_readdata;
  logic [3:0]  m1_byteenable;
  logic        m1_read, m1_write, m1_waitrequest;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic [3:0]  s_byteenable;
  logic        s_read, s_write, s_waitrequest;
  logic [1:0]  owner;
  logic        timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  mips_bus_arbiter #(.WAIT_LIMIT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .m0_address    (m0_address),
    .m0_writedata  (m0_writedata),
    .m0_byteenable (m0_byteenable),
    .m0_read       (m0_read),
    .m0_write      (m0_write),
    .m0_readdata   (m0_readdata),
    .m0_waitrequest(m0_waitrequest),
    .m1_address    (m1_address),
    .m1_writedata  (m1_writedata),
    .m1_byteenable (m1_byteenable),
    .m1_read       (m1_read),
    .m1_write      (m1_write),
    .m1_readdata   (m1_readdata),
    .m1_waitrequest(m1_waitrequest),
    .s_address     (s_address),
    .s_writedata   (s_writedata),
    .s_byteenable  (s_byteenable),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_readdata    (s_readdata),
    .s_waitrequest (s_waitrequest),
    .owner         (owner),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    // Both masters request while reset is held low.
    reset = 1'b0;
    m0_address = 32'h0000_0A00; m0_writedata = 32'h0; m0_byteenable = 4'hF;
    m0_read = 1'b1; m0_write = 1'b0;
    m1_address = 32'h0000_0B00; m1_writedata = 32'hCAFE_F00D; m1_byteenable = 4'hF;
    m1_read = 1'b0; m1_write = 1'b1;
    s_readdata = 32'h1111_2222; s_waitrequest = 1'b0;
    #3;
    check_output("rst_owner", 32'(owner), 32'd0);
    check_output("rst_s_read", 32'(s_read), 32'd0);
    check_output("rst_s_write", 32'(s_write), 32'd0);
    check_output("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
    check_output("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
    check_output("rst_timeout_err", 32'(timeout_err), 32'd0);
    check_output("rst_m0_rdata", m0_readdata, 32'h1111_2222);
    check_output("rst_m1_rdata", m1_readdata, 32'h1111_2222);
    tick();
    reset = 1'b1;

    // Tie after reset goes to master 0, then straight to master 1.
    tick(); #1;
    check_output("tie_owner0", 32'(owner), 32'd1);
    check_output("tie_s_read", 32'(s_read), 32'd1);
    check_output("tie_s_write", 32'(s_write), 32'd0);
    check_output("tie_s_addr0", s_address, 32'h0000_0A00);
    check_output("tie_m0_wait", 32'(m0_waitrequest), 32'd0);
    check_output("tie_m1_wait", 32'(m1_waitrequest), 32'd1);
    tick();
    m0_read = 1'b0;
    #1;
    check_output("tie_owner1", 32'(owner), 32'd2);
    check_output("tie_s_write1", 32'(s_write), 32'd1);
    check_output("tie_s_addr1", s_address, 32'h0000_0B00);
    check_output("tie_s_wdata1", s_writedata, 32'hCAFE_F00D);
    check_output("tie_m1_wait_own", 32'(m1_waitrequest), 32'd0);
    tick();
    m1_write = 1'b0;
    #1;
    check_output("tie_idle", 32'(owner), 32'd0);

    // Boot fetch, zero-wait slave.
    m0_read = 1'b1; m0_address = 32'hBFC0_0000; s_readdata = 32'h2402_0005;
    #1;
    check_output("fetch_owner_pre", 32'(owner), 32'd0);
    check_output("fetch_wait_pre", 32'(m0_waitrequest), 32'd1);
    check_output("fetch_s_read_pre", 32'(s_read), 32'd0);
    tick(); #1;
    check_output("fetch_owner", 32'(owner), 32'd1);
    check_output("fetch_s_addr", s_address, 32'hBFC0_0000);
    check_output("fetch_s_read", 32'(s_read), 32'd1);
    check_output("fetch_m0_wait", 32'(m0_waitrequest), 32'd0);
    check_output("fetch_rdata", m0_readdata, 32'h2402_0005);
    tick();
    m0_read = 1'b0;
    #1;
    check_output("fetch_idle", 32'(owner), 32'd0);

    // Continuous contention; master 0 just finished so master 1 wins first.
    m0_read = 1'b1; m0_address = 32'h0000_0100;
    m1_read = 1'b1; m1_address = 32'h0000_0200;
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      check_output($sformatf("rr_owner_%0d", i), 32'(owner), (i % 2 == 0) ? 32'd2 : 32'd1);
      check_output($sformatf("rr_addr_%0d", i), s_address,
                   (i % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100);
    end
    // Master 0 abandons; last grant stays with master 1, so master 0 wins the next tie.
    m0_read = 1'b0; m1_read = 1'b0;
    tick(); #1;
    check_output("abandon_idle", 32'(owner), 32'd0);
    m0_read = 1'b1; m1_read = 1'b1;
    tick(); #1;
    check_output("abandon_regrant", 32'(owner), 32'd1);
    m0_read = 1'b0; m1_read = 1'b0;
    tick(); #1;
    check_output("abandon_idle2", 32'(owner), 32'd0);

    // Master 1 write with read also raised, slave stalls three cycles.
    m1_write = 1'b1; m1_read = 1'b1;
    m1_address = 32'h0000_1000; m1_writedata = 32'h1234_5678; m1_byteenable = 4'b0011;
    s_waitrequest = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) tick();
      s_waitrequest = (k < 4);
      #1;
      check_output($sformatf("wr_owner_%0d", k), 32'(owner), 32'd2);
      check_output($sformatf("wr_s_write_%0d", k), 32'(s_write), 32'd1);
      check_output($sformatf("wr_s_read_%0d", k), 32'(s_read), 32'd0);
      check_output($sformatf("wr_s_addr_%0d", k), s_address, 32'h0000_1000);
      check_output($sformatf("wr_s_wdata_%0d", k), s_writedata, 32'h1234_5678);
      check_output($sformatf("wr_s_be_%0d", k), 32'(s_byteenable), 32'h3);
      check_output($sformatf("wr_m1_wait_%0d", k), 32'(m1_waitrequest), (k < 4) ? 32'd1 : 32'd0);
    end
    tick();
    m1_write = 1'b0; m1_read = 1'b0;
    #1;
    check_output("wr_idle", 32'(owner), 32'd0);

    // Reset asserted in the middle of a stalled master 1 write.
    m1_write = 1'b1; m1_address = 32'h0000_2000; m1_writedata = 32'hAAAA_5555; m1_byteenable = 4'hF;
    s_waitrequest = 1'b1;
    tick(); #1;
    check_output("mid_owner", 32'(owner), 32'd2);
    check_output("mid_s_write", 32'(s_write), 32'd1);
    reset = 1'b0;
    #1;
    check_output("mid_rst_s_write", 32'(s_write), 32'd0);
    check_output("mid_rst_owner", 32'(owner), 32'd0);
    check_output("mid_rst_m1_wait", 32'(m1_waitrequest), 32'd1);
    tick();
    tick();
    reset = 1'b1;
    tick(); #1;
    check_output("mid_regrant", 32'(owner), 32'd2);
    check_output("mid_regrant_write", 32'(s_write), 32'd1);
    s_waitrequest = 1'b0;
    tick();
    m1_write = 1'b0;
    #1;
    check_output("mid_idle", 32'(owner), 32'd0);

    // Slave never releases master 0.
    m0_read = 1'b1; m0_address = 32'h0000_3000;
    s_readdata = 32'hDEAD_BEEF; s_waitrequest = 1'b1;
    tick();
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) tick();
      #1;
      check_output($sformatf("to_owner_%0d", k), 32'(owner), 32'd1);
      check_output($sformatf("to_m0_wait_%0d", k), 32'(m0_waitrequest), (k < 4) ? 32'd1 : 32'd0);
      check_output($sformatf("to_m0_rdata_%0d", k), m0_readdata,
                   (k == 4) ? 32'hFFFF_FFFF : 32'hDEAD_BEEF);
      check_output($sformatf("to_m1_rdata_%0d", k), m1_readdata, 32'hDEAD_BEEF);
      check_output($sformatf("to_err_%0d", k), 32'(timeout_err), 32'd0);
    end
    tick();
    m0_read = 1'b0;
    #1;
    check_output("to_idle", 32'(owner), 32'd0);
    check_output("to_err_set", 32'(timeout_err), 32'd1);
    s_waitrequest = 1'b0;
    tick();
    tick(); #1;
    check_output("to_err_sticky", 32'(timeout_err), 32'd1);
`else
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) tick();
      #1;
      check_output($sformatf("stall_owner_%0d", k), 32'(owner), 32'd1);
      check_output($sformatf("stall_m0_wait_%0d", k), 32'(m0_waitrequest), 32'd1);
      check_output($sformatf("stall_err_%0d", k), 32'(timeout_err), 32'd0);
    end
    s_waitrequest = 1'b0;
    #1;
    check_output("stall_release_wait", 32'(m0_waitrequest), 32'd0);
    check_output("stall_release_rdata", m0_readdata, 32'hDEAD_BEEF);
    tick();
    m0_read = 1'b0;
    #1;
    check_output("stall_idle", 32'(owner), 32'd0);
    check_output("stall_err_final", 32'(timeout_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
